nios_debug_scan_master: RTL and testbench
=========================================

# nios_debug_scan_master

Single-clock initiator for the Nios II debug slave's virtual-JTAG scan interface. It accepts one command, holding a 2-bit IR value and a 38-bit DR word, on a valid/ready handshake. It sequences the virtual-JTAG state strobes and the serial tdi/tdo shift toward the debug slave, then returns the captured readback word on a response handshake. It sits between a bench or on-chip debug host and the debug slave's `ir_in`/`tdi`/`tdo`/`vs_*` ports, replacing the physical JTAG hub.

## Interface
- `DR_WIDTH`, 38, DR shift length in bits (≥2)
- `IR_WIDTH`, 2, IR width in bits
- `TCK_DIV`, 4, clk cycles per scan tick (≥1)

Ports:
- `clk` in 1 — sole clock, all logic rising-edge
- `reset` in 1 — synchronous, active-high
- `cmd_valid` in 1 — command offered
- `cmd_ready` out 1 — block idle, command accepted when both high
- `cmd_ir` in IR_WIDTH — IR value to load
- `cmd_dr` in DR_WIDTH — DR word to shift out, LSB first
- `cmd_ir_only` in 1 — 1: UIR only, no DR scan
- `rsp_valid` out 1 — response available, held until `rsp_ready`
- `rsp_ready` in 1 — response consumed
- `rsp_data` out DR_WIDTH — captured tdo bits
- `rsp_ir_out` out IR_WIDTH — `jtag_ir_out` sampled at UIR tick
- `jtag_tck` out 1 — one-cycle tick pulse, last cycle of each scan state
- `jtag_tdi` out 1 — serial data to slave
- `jtag_tdo` in 1 — serial data from slave
- `jtag_ir_in` out IR_WIDTH — IR value, held from UIR until return to IDLE
- `jtag_ir_out` in IR_WIDTH — slave IR status
- `vs_uir`, `vs_cdr`, `vs_sdr`, `vs_e1dr`, `jtag_rti` out 1 each — state levels

## Operation
- States: IDLE, UIR, CDR, SDR, E1DR, RTI, RESP. Exactly one state-level output is high in UIR/CDR/SDR/E1DR/RTI. None is high in IDLE or RESP.
- Transitions:
  - Accept in IDLE → UIR.
  - UIR tick → CDR, or → RTI if `cmd_ir_only` was latched.
  - CDR tick → SDR.
  - SDR after DR_WIDTH ticks → E1DR.
  - E1DR tick → RTI.
  - RTI tick → RESP.
  - RESP with `rsp_ready` → IDLE.
- On accept, latch `cmd_ir`→`jtag_ir_in`, `cmd_dr`→shift reg `sr`, and `cmd_ir_only`.
- Tick counter `div_cnt` runs 0..TCK_DIV-1 in non-IDLE/RESP states and resets to 0 on every state change. A tick occurs when `div_cnt==TCK_DIV-1`. `jtag_tck` is high exactly on that cycle.
- SDR:
  - `jtag_tdi = sr[0]`.
  - Each tick: `sr <= {jtag_tdo, sr[DR_WIDTH-1:1]}`.
  - A bit counter counts 0..DR_WIDTH-1, with the leave condition at count DR_WIDTH-1 on a tick.
  - `jtag_tdi` is 0 outside SDR.
- UIR tick: sample `jtag_ir_out` into `rsp_ir_out`.
- RESP: `rsp_valid=1`, `rsp_data=sr`. IR-only commands return `rsp_data` equal to the unmodified `cmd_dr`.
- `cmd_ready=1` only in IDLE. `cmd_valid` in any other state is ignored and nothing is queued.
- Reset values:
  - `cmd_ready=1`.
  - All other outputs 0: `rsp_valid`, `rsp_data`, `rsp_ir_out`, `jtag_*`, `vs_*`.
- Reset mid-operation returns to IDLE on the next edge. The partial scan is discarded and no response is produced.

## Timing
- Accept cycle = cycle 0; UIR is entered at cycle 1.
- Each state lasts TCK_DIV cycles; SDR lasts DR_WIDTH×TCK_DIV cycles.
- Full command: `rsp_valid` rises at cycle 1+(DR_WIDTH+4)×TCK_DIV. Defaults: cycle 169.
- IR-only command: `rsp_valid` rises at cycle 1+2×TCK_DIV. Default: cycle 9.
- `jtag_tdo` is sampled only on SDR tick cycles. The slave must present bit k before the k-th SDR tick.
- RESP→IDLE takes one cycle after `rsp_valid&&rsp_ready`. `cmd_ready` rises the next cycle, so the minimum gap between commands is 1 idle cycle.
- TCK_DIV=1: every state-level output is one cycle wide, with `jtag_tck` high for that cycle.

## Configuration
- `DEBUG_SCAN_READBACK_EN` defined:
  - tdo is shifted into `sr`.
  - `rsp_data` returns captured bits.
- Undefined:
  - `jtag_tdo` is ignored; `sr` shifts in 0.
  - `rsp_data` is forced to 0.
  - `rsp_ir_out` still captured; timing unchanged.

## Test plan
- Reset: hold `reset` 3 cycles, mid-SDR → next cycle `cmd_ready=1`, all other outputs 0, and no `rsp_valid` ever follows.
- IR-only, `cmd_ir=2'b01`, `jtag_ir_out=2'b10`, defaults →
  - `vs_uir` high cycles 1–4, `jtag_tck` at 4.
  - `jtag_rti` high cycles 5–8, `jtag_tck` at 8.
  - `rsp_valid` at 9 with `rsp_ir_out=2'b10`.
- Full DR, `cmd_dr=38'h15_5555_AAAA`, slave model returns `38'h2A_AAAA_5555` LSB first →
  - `jtag_tdi` bit k equals `cmd_dr[k]` on the k-th SDR tick.
  - `rsp_valid` at cycle 169, `rsp_data=38'h2A_AAAA_5555` (with `DEBUG_SCAN_READBACK_EN`).
- Back-pressure: `rsp_ready=0` for 20 cycles → `rsp_valid`/`rsp_data` stable, `cmd_ready=0`, and a second `cmd_valid` is ignored. Then `rsp_ready=1` → IDLE next cycle, second command accepted the cycle after.
- TCK_DIV=1, DR_WIDTH=38 → `jtag_tck` high every cycle from 1 to 42, `rsp_valid` at cycle 43.
- Macro undefined, same full-DR stimulus → `rsp_data=0`, `rsp_valid` still at cycle 169.

Source files
------------

// File: rtl/nios_debug_scan_master.sv
// Virtual-JTAG scan initiator for the Nios II debug slave: one IR/DR command in, one readback out.
// Optional macro DEBUG_SCAN_READBACK_EN: when defined, tdo is captured and returned in rsp_data.
module nios_debug_scan_master #(
   parameter int DR_WIDTH = 38,
   parameter int IR_WIDTH = 2,
   parameter int TCK_DIV  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   input  logic                cmd_ir_only,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_data,
   output logic [IR_WIDTH-1:0] rsp_ir_out,
   output logic                jtag_tck,
   output logic                jtag_tdi,
   input  logic                jtag_tdo,
   output logic [IR_WIDTH-1:0] jtag_ir_in,
   input  logic [IR_WIDTH-1:0] jtag_ir_out,
   output logic                vs_uir,
   output logic                vs_cdr,
   output logic                vs_sdr,
   output logic                vs_e1dr,
   output logic                jtag_rti,
   output logic [2:0]          dbg_state
);

`ifdef DEBUG_SCAN_READBACK_EN
   localparam bit READBACK_EN = 1'b1;
`else
   localparam bit READBACK_EN = 1'b0;
`endif

   localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
   localparam int BIT_W = $clog2(DR_WIDTH);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TCK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DR_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_UIR  = 3'd1,
      S_CDR  = 3'd2,
      S_SDR  = 3'd3,
      S_E1DR = 3'd4,
      S_RTI  = 3'd5,
      S_RESP = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [DR_WIDTH-1:0] sr_q, sr_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d;
   logic [IR_WIDTH-1:0] ir_out_q, ir_out_d;
   logic                ir_only_q, ir_only_d;
   logic                scan, tick, shift_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         div_q     <= '0;
         bit_q     <= '0;
         sr_q      <= '0;
         ir_q      <= '0;
         ir_out_q  <= '0;
         ir_only_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         sr_q      <= sr_d;
         ir_q      <= ir_d;
         ir_out_q  <= ir_out_d;
         ir_only_q <= ir_only_d;
      end
   end

   // With readback disabled the shifter fills with zeros; scan timing is identical.
   assign shift_in = jtag_tdo & READBACK_EN;
   assign scan = (state_q != S_IDLE) && (state_q != S_RESP);
   assign tick = scan && (div_q == DIV_MAX);

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_d     = bit_q;
      sr_d      = sr_q;
      ir_d      = ir_q;
      ir_out_d  = ir_out_q;
      ir_only_d = ir_only_q;
      if (scan) div_d = tick ? '0 : DIV_W'(div_q + 1'b1);
      case (state_q)
         S_IDLE: if (cmd_valid) begin
            state_d   = S_UIR;
            sr_d      = cmd_dr;
            ir_d      = cmd_ir;
            ir_only_d = cmd_ir_only;
            div_d     = '0;
            bit_d     = '0;
         end
         S_UIR: if (tick) begin
            ir_out_d = jtag_ir_out;
            state_d  = ir_only_q ? S_RTI : S_CDR;
         end
         S_CDR: if (tick) begin
            state_d = S_SDR;
            bit_d   = '0;
         end
         S_SDR: if (tick) begin
            sr_d  = {shift_in, sr_q[DR_WIDTH-1:1]};
            bit_d = BIT_W'(bit_q + 1'b1);
            if (bit_q == BIT_MAX) state_d = S_E1DR;
         end
         S_E1DR: if (tick) state_d = S_RTI;
         S_RTI:  if (tick) state_d = S_RESP;
         S_RESP: if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign cmd_ready  = (state_q == S_IDLE);
   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_data   = (rsp_valid && READBACK_EN) ? sr_q : '0;
   assign rsp_ir_out = ir_out_q;
   assign jtag_tck   = tick;
   assign jtag_tdi   = (state_q == S_SDR) && sr_q[0];
   assign jtag_ir_in = (state_q != S_IDLE) ? ir_q : '0;
   assign vs_uir     = (state_q == S_UIR);
   assign vs_cdr     = (state_q == S_CDR);
   assign vs_sdr     = (state_q == S_SDR);
   assign vs_e1dr    = (state_q == S_E1DR);
   assign jtag_rti   = (state_q == S_RTI);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_nios_debug_scan_master.sv
// Directed bench for nios_debug_scan_master: default timing instance plus a TCK_DIV=1 instance.
module tb_nios_debug_scan_master;
   localparam int DRW = 38;
`ifdef DEBUG_SCAN_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic cmd_valid = 0, cmd_ready, cmd_ir_only = 0, rsp_valid, rsp_ready = 0;
   logic [1:0] cmd_ir = '0, rsp_ir_out, jtag_ir_in, jtag_ir_out = '0;
   logic [DRW-1:0] cmd_dr = '0, rsp_data;
   logic jtag_tck, jtag_tdi, jtag_tdo = 0, vs_uir, vs_cdr, vs_sdr, vs_e1dr, jtag_rti;
   logic [2:0] dbg_state;

   logic f_cmd_valid = 0, f_cmd_ready, f_cmd_ir_only = 0, f_rsp_valid, f_rsp_ready = 0;
   logic [1:0] f_cmd_ir = '0, f_rsp_ir_out, f_jtag_ir_in, f_jtag_ir_out = '0;
   logic [DRW-1:0] f_cmd_dr = '0, f_rsp_data;
   logic f_jtag_tck, f_jtag_tdi, f_jtag_tdo = 0, f_vs_uir, f_vs_cdr, f_vs_sdr, f_vs_e1dr, f_jtag_rti;
   logic [2:0] f_dbg_state;

   nios_debug_scan_master u_dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .cmd_ir_only(cmd_ir_only),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_ir_out(rsp_ir_out), .jtag_tck(jtag_tck), .jtag_tdi(jtag_tdi),
      .jtag_tdo(jtag_tdo), .jtag_ir_in(jtag_ir_in), .jtag_ir_out(jtag_ir_out),
      .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_e1dr(vs_e1dr),
      .jtag_rti(jtag_rti), .dbg_state(dbg_state)
   );

   nios_debug_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(2), .TCK_DIV(1)) u_fast (
      .clk(clk), .reset(reset), .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready),
      .cmd_ir(f_cmd_ir), .cmd_dr(f_cmd_dr), .cmd_ir_only(f_cmd_ir_only),
      .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_data(f_rsp_data),
      .rsp_ir_out(f_rsp_ir_out), .jtag_tck(f_jtag_tck), .jtag_tdi(f_jtag_tdi),
      .jtag_tdo(f_jtag_tdo), .jtag_ir_in(f_jtag_ir_in), .jtag_ir_out(f_jtag_ir_out),
      .vs_uir(f_vs_uir), .vs_cdr(f_vs_cdr), .vs_sdr(f_vs_sdr), .vs_e1dr(f_vs_e1dr),
      .jtag_rti(f_jtag_rti), .dbg_state(f_dbg_state)
   );

   int checks = 0;
   int failures = 0;
   logic [0:0]     tdi_q[$];
   logic [DRW-1:0] exp_q[$];
   logic [255:0]   uir_tr, cdr_tr, rti_tr, tck_tr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [49:0] out_vec();
      return {rsp_valid, rsp_data, rsp_ir_out, jtag_tck, jtag_tdi, jtag_ir_in,
              vs_uir, vs_cdr, vs_sdr, vs_e1dr, jtag_rti};
   endfunction

   task automatic push_tdi(input logic [DRW-1:0] dr);
      for (int i = 0; i < DRW; i++) tdi_q.push_back(dr[i]);
   endtask

   task automatic check_rsp(input string tag);
      if (exp_q.size() > 0) chk(tag, rsp_data, exp_q.pop_front());
      else chk({tag, "_unexpected"}, 1, 0);
   endtask

   // Caller has cmd_valid high in IDLE; the next edge is the accept (cycle 0).
   task automatic run_cmd(input int stop_at, input logic [DRW-1:0] slave_word, output int rsp_cyc);
      int k = 0;
      int c = 1;
      uir_tr = '0; cdr_tr = '0; rti_tr = '0; tck_tr = '0;
      rsp_cyc = -1;
      @(posedge clk); #1;
      cmd_valid = 0;
      while (c < 400) begin
         if (stop_at != 0 && c == stop_at) break;
         if (rsp_valid) begin
            rsp_cyc = c;
            break;
         end
         if (c < 256) begin
            uir_tr[c] = vs_uir; cdr_tr[c] = vs_cdr; rti_tr[c] = jtag_rti; tck_tr[c] = jtag_tck;
         end
         jtag_tdo = (vs_sdr && k < DRW) ? slave_word[k] : 1'b0;
         if (vs_sdr && jtag_tck) begin
            if (tdi_q.size() > 0) chk($sformatf("tdi_bit%0d", k), jtag_tdi, tdi_q.pop_front());
            else chk("tdi_extra_tick", 1, 0);
            k++;
         end
         @(posedge clk); #1;
         c++;
      end
      jtag_tdo = 0;
      if (stop_at == 0 && rsp_cyc < 0) chk("rsp_timeout", 1, 0);
   endtask

   task automatic release_rsp();
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
   endtask

   initial begin
      int rc;
      int c;
      logic stable, saw;
      logic [DRW-1:0] held;
      logic [63:0] fexp;
      logic [DRW-1:0] slave;

      // Reset held 3 cycles
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {14'd0, out_vec()}, 64'd0);
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_fast_ready", f_cmd_ready, 1);
      reset = 0;
      @(posedge clk); #1;

      // IR-only command
      cmd_ir = 2'b01; cmd_dr = 38'h0A_1234_5678; cmd_ir_only = 1; jtag_ir_out = 2'b10;
      exp_q.push_back(RB ? cmd_dr : '0);
      cmd_valid = 1;
      run_cmd(0, '0, rc);
      chk("iro_rsp_cycle", rc, 9);
      chk("iro_vs_uir", uir_tr[15:0], 16'h001E);
      chk("iro_jtag_rti", rti_tr[15:0], 16'h01E0);
      chk("iro_tck", tck_tr[15:0], 16'h0110);
      chk("iro_no_cdr", cdr_tr[15:0], 16'h0000);
      chk("iro_rsp_ir_out", rsp_ir_out, 2'b10);
      chk("iro_ir_in_held", jtag_ir_in, 2'b01);
      check_rsp("iro_rsp_data");
      release_rsp();
      chk("iro_back_idle", {cmd_ready, rsp_valid}, 2'b10);

      // Full DR scan, then back-pressure with a second command offered
      slave = 38'h2A_AAAA_5555;
      cmd_ir = 2'b11; cmd_dr = 38'h15_5555_AAAA; cmd_ir_only = 0; jtag_ir_out = 2'b01;
      push_tdi(cmd_dr);
      exp_q.push_back(RB ? slave : '0);
      cmd_valid = 1;
      run_cmd(0, slave, rc);
      chk("dr_rsp_cycle", rc, 169);
      chk("dr_tdi_all_seen", tdi_q.size(), 0);
      chk("dr_rsp_ir_out", rsp_ir_out, 2'b01);
      check_rsp("dr_rsp_data");
      held = rsp_data;
      cmd_ir = 2'b10; cmd_dr = 38'h00_0000_00FF; cmd_ir_only = 1; jtag_ir_out = 2'b11;
      cmd_valid = 1;
      stable = 1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (!(rsp_valid === 1'b1 && rsp_data === held && cmd_ready === 1'b0)) stable = 0;
      end
      chk("bp_stable", stable, 1);
      release_rsp();
      chk("bp_release_idle", {cmd_ready, rsp_valid}, 2'b10);
      exp_q.push_back(RB ? 38'h00_0000_00FF : '0);
      run_cmd(0, '0, rc);
      chk("bp_second_rsp_cycle", rc, 9);
      chk("bp_second_ir_out", rsp_ir_out, 2'b11);
      check_rsp("bp_second_rsp_data");
      release_rsp();

      // Reset in the middle of SDR
      cmd_ir = 2'b01; cmd_dr = 38'h3C_0F0F_F0F0; cmd_ir_only = 0;
      push_tdi(cmd_dr);
      cmd_valid = 1;
      run_cmd(50, slave, rc);
      chk("mid_in_sdr", vs_sdr, 1);
      reset = 1;
      @(posedge clk); #1;
      chk("mid_reset_outputs", {14'd0, out_vec()}, 64'd0);
      chk("mid_reset_ready", cmd_ready, 1);
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      tdi_q.delete();
      saw = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) saw = 1;
      end
      chk("mid_no_rsp", saw, 0);

      // TCK_DIV=1 instance: one tick per cycle
      f_cmd_ir = 2'b10; f_cmd_dr = 38'h12_3456_789A; f_cmd_ir_only = 0; f_jtag_tdo = 1;
      f_cmd_valid = 1;
      @(posedge clk); #1;
      f_cmd_valid = 0;
      tck_tr = '0;
      rc = -1;
      c = 1;
      while (c < 200) begin
         if (f_rsp_valid) begin
            rc = c;
            break;
         end
         if (c < 256) tck_tr[c] = f_jtag_tck;
         @(posedge clk); #1;
         c++;
      end
      fexp = '0;
      for (int i = 1; i <= 42; i++) fexp[i] = 1'b1;
      chk("fast_rsp_cycle", rc, 43);
      chk("fast_tck", tck_tr[63:0], fexp);
      chk("fast_rsp_data", f_rsp_data, RB ? {DRW{1'b1}} : '0);
      f_rsp_ready = 1;
      @(posedge clk); #1;
      f_rsp_ready = 0;
      chk("fast_back_idle", {f_cmd_ready, f_rsp_valid}, 2'b10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
